// File: rtl/seq_pattern_tx_pkg.sv
// ----------------------------------------------------------------------------
// seq_pattern_tx_pkg
//   Shared types and defaults for the serial pattern transmitter.
//   - state_t     : transmitter FSM state encoding
//   - DEF_*       : default parameter values for WIDTH / LEN_W / CNT_W
//   - gap_w()     : width of the inter-pass gap counter (never below 1 bit)
// ----------------------------------------------------------------------------
package seq_pattern_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_LEN_W = 5;
    localparam int DEF_CNT_W = 4;

    // A zero-length gap still needs a 1-bit counter so the vector is legal.
    function automatic int gap_w(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/seq_pattern_shreg.sv
// ----------------------------------------------------------------------------
// seq_pattern_shreg
//   Loadable WIDTH-bit left shifter holding the pattern left-aligned, so the
//   bit to transmit next always sits at the MSB. A saved copy allows the
//   pattern to be replayed for repeat passes without re-sampling the inputs.
//
//   Ports:
//     clk, reset  rising-edge clock, asynchronous active-high reset
//     en          clock enable; nothing changes while low
//     load        capture pattern/nbits (first bit leaves at this same edge)
//     shift       advance to the next lower bit
//     reload      restart the saved pattern (first bit leaves at this edge)
//     pattern     parallel pattern, bit nbits-1 is sent first
//     nbits       pass length, already saturated to 0..WIDTH
//     msb         bit to present at the coming edge
//     last_bit    the bit currently on the line is bit 0 of the pass
// ----------------------------------------------------------------------------
module seq_pattern_shreg
    import seq_pattern_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             shift,
    input  logic             reload,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] nbits,
    output logic             msb,
    output logic             last_bit
);

    logic [WIDTH-1:0] aligned;
    logic [WIDTH-1:0] saved_q;
    logic [WIDTH-1:0] work_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx_q;

    // Push bit nbits-1 up to the MSB; LEN_W is wide enough to hold WIDTH.
    assign aligned = pattern << (LEN_W'(WIDTH) - nbits);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values regardless of statement order.
    // NOTE: the pattern stores are reset as well, so msb and last_bit are
    // defined from the first cycle out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            saved_q <= '0;
            work_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
        end else if (en) begin
            if (load) begin
                // The MSB leaves at this edge, so the working copy starts
                // already shifted by one.
                saved_q <= aligned;
                work_q  <= aligned << 1;
                len_q   <= nbits;
                idx_q   <= nbits - LEN_W'(1);
            end else if (reload) begin
                work_q <= saved_q << 1;
                idx_q  <= len_q - LEN_W'(1);
            end else if (shift) begin
                work_q <= work_q << 1;
                idx_q  <= idx_q - LEN_W'(1);
            end
        end
    end

    // On load/reload the outgoing bit is not yet in work_q; bypass it.
    assign msb      = load   ? aligned[WIDTH-1] :
                      reload ? saved_q[WIDTH-1] : work_q[WIDTH-1];
    assign last_bit = (idx_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// ----------------------------------------------------------------------------
// seq_pattern_tx
//   Serial pattern transmitter driving the single-bit sequence-detector
//   interface. Sends nbits of pattern MSB-first, one bit per enabled clock,
//   for repeats+1 passes, with GAP_CYCLES idle cycles between passes.
//
//   Ports:
//     clk      rising-edge clock
//     reset    asynchronous active-high reset; aborts any transmission
//     en       clock enable; when low all state and outputs hold
//     start    request transmission, sampled only in IDLE with en=1
//     pattern  WIDTH-bit pattern, bit nbits-1 sent first
//     nbits    bits per pass, 0..WIDTH (larger values saturate to WIDTH)
//     repeats  number of additional passes (0 = single pass)
//     xout     registered serial data (to detector xin)
//     valid    xout carries a pattern bit this cycle
//     busy     transmission in progress
//     done     one-cycle completion pulse (stretched while en=0)
// ----------------------------------------------------------------------------
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] nbits,
    input  logic [CNT_W-1:0] repeats,
    output logic             xout,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int                GAP_W    = gap_w(GAP_CYCLES);
    // The entering edge already counts as the first gap cycle.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] pass_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [LEN_W-1:0] nbits_sat;

    logic accept;
    logic do_shift;
    logic do_reload;
    logic more_passes;
    logic shreg_msb;
    logic last_bit;

    assign nbits_sat = (nbits > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : nbits;

    // Per-state decode shared by the FSM and the shifter.
    // NOTE: every always_comb output gets a default first so no path through
    // the case leaves a signal unassigned (which would infer a latch).
    always_comb begin
        accept      = 1'b0;
        do_shift    = 1'b0;
        do_reload   = 1'b0;
        more_passes = 1'b0;
        case (state)
            IDLE:  accept = start;
            SHIFT: begin
                if (!last_bit) begin
                    do_shift = 1'b1;
                end else if (pass_cnt != '0) begin
                    more_passes = 1'b1;
                    do_reload   = (GAP_CYCLES == 0);
                end
            end
            GAP:   do_reload = (gap_cnt == '0);
            default: ;
        endcase
    end

    seq_pattern_shreg #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_shreg (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (accept),
        .shift    (do_shift),
        .reload   (do_reload),
        .pattern  (pattern),
        .nbits    (nbits_sat),
        .msb      (shreg_msb),
        .last_bit (last_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pass_cnt <= '0;
            gap_cnt  <= '0;
            xout     <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (en) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        pass_cnt <= repeats;
                        if (nbits_sat == '0) begin
                            state <= DONE;
                            xout  <= 1'b0;
                            valid <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= SHIFT;
                            xout  <= shreg_msb;
                            valid <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (!last_bit) begin
                        xout <= shreg_msb;
                    end else if (more_passes) begin
                        pass_cnt <= pass_cnt - CNT_W'(1);
                        if (GAP_CYCLES == 0) begin
                            // Next pass MSB follows bit 0 with no bubble.
                            xout <= shreg_msb;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= GAP_LOAD;
                            xout    <= 1'b0;
                            valid   <= 1'b0;
                        end
                    end else begin
                        state <= DONE;
                        xout  <= 1'b0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= SHIFT;
                        xout  <= shreg_msb;
                        valid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// ----------------------------------------------------------------------------
// tb_seq_pattern_tx
//   Directed bench for seq_pattern_tx. Two instances share the stimulus:
//   dut uses a 2-cycle inter-pass gap, dut0 runs passes back-to-back.
// ----------------------------------------------------------------------------
module tb_seq_pattern_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        start;
    logic [15:0] pattern;
    logic [4:0]  nbits;
    logic [3:0]  repeats;

    logic xout,  valid,  busy,  done;
    logic xout0, valid0, busy0, done0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_pattern_tx #(
        .WIDTH(16), .LEN_W(5), .CNT_W(4), .GAP_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .start(start),
        .pattern(pattern), .nbits(nbits), .repeats(repeats),
        .xout(xout), .valid(valid), .busy(busy), .done(done)
    );

    seq_pattern_tx #(
        .WIDTH(16), .LEN_W(5), .CNT_W(4), .GAP_CYCLES(0)
    ) dut0 (
        .clk(clk), .reset(reset), .en(en), .start(start),
        .pattern(pattern), .nbits(nbits), .repeats(repeats),
        .xout(xout0), .valid(valid0), .busy(busy0), .done(done0)
    );

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for both instances to return to idle.
    task automatic wait_idle();
        int n = 0;
        while ((busy || done || busy0 || done0) && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (busy || done || busy0 || done0) begin
            errors++;
            $display("FAIL wait_idle timeout busy=%b done=%b busy0=%b done0=%b", busy, done, busy0, done0);
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; start = 1'b0;
        pattern = '0; nbits = '0; repeats = '0;
        step();
        step();
        checks++;
        if ({xout, valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold got=%b exp=0000", {xout, valid, busy, done});
        end
        reset = 1'b0;
        step();
        checks++;
        if ({xout0, valid0, busy0, done0, xout, valid, busy, done} !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle got=%b exp=00000000", {xout0, valid0, busy0, done0, xout, valid, busy, done});
        end
    endtask

    task automatic test_single();
        logic [3:0] exp [5];
        exp = '{4'b1110, 4'b0110, 4'b1110, 4'b0001, 4'b0000};
        pattern = 16'h0005; nbits = 5'd3; repeats = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            checks++;
            if ({xout, valid, busy, done} !== exp[i]) begin
                errors++;
                $display("FAIL single cyc%0d xvbd got=%b exp=%b", i, {xout, valid, busy, done}, exp[i]);
            end
        end
    endtask

    task automatic test_detector();
        logic [10:0] exp_bits;
        exp_bits = 11'b01011100100;
        pattern = 16'h02E4; nbits = 5'd11; repeats = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 10; i >= 0; i--) begin
            if (i < 10) step();
            checks++;
            if ({xout, valid} !== {exp_bits[i], 1'b1}) begin
                errors++;
                $display("FAIL detector bit%0d xv got=%b exp=%b", 10 - i, {xout, valid}, {exp_bits[i], 1'b1});
            end
        end
        step();
        checks++;
        if ({valid, busy, done} !== 3'b001) begin
            errors++;
            $display("FAIL detector_done vbd got=%b exp=001", {valid, busy, done});
        end
        wait_idle();
    endtask

    task automatic test_repeat_gap();
        logic [5:0] exp_x, exp_v;
        exp_x = 6'b100010;
        exp_v = 6'b110011;
        pattern = 16'h0002; nbits = 5'd2; repeats = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            if (i < 5) step();
            checks++;
            if ({xout, valid, busy} !== {exp_x[i], exp_v[i], 1'b1}) begin
                errors++;
                $display("FAIL repeat_gap cyc%0d xvb got=%b exp=%b", 5 - i, {xout, valid, busy}, {exp_x[i], exp_v[i], 1'b1});
            end
        end
        step();
        checks++;
        if ({xout, valid, busy, done} !== 4'b0001) begin
            errors++;
            $display("FAIL repeat_gap_done xvbd got=%b exp=0001", {xout, valid, busy, done});
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_x;
        exp_x = 6'b101010;
        pattern = 16'h0002; nbits = 5'd2; repeats = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            if (i < 5) step();
            checks++;
            if ({xout0, valid0, busy0} !== {exp_x[i], 2'b11}) begin
                errors++;
                $display("FAIL back_to_back cyc%0d xvb got=%b exp=%b", 5 - i, {xout0, valid0, busy0}, {exp_x[i], 2'b11});
            end
        end
        step();
        checks++;
        if ({xout0, valid0, busy0, done0} !== 4'b0001) begin
            errors++;
            $display("FAIL back_to_back_done xvbd got=%b exp=0001", {xout0, valid0, busy0, done0});
        end
        wait_idle();
    endtask

    task automatic test_en_freeze();
        logic [7:0] exp_bits;
        int vcount = 0;
        exp_bits = 8'b10100111;
        pattern = 16'h00A7; nbits = 5'd8; repeats = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (i < 7) step();
            if (valid) vcount++;
            checks++;
            if ({xout, valid} !== {exp_bits[i], 1'b1}) begin
                errors++;
                $display("FAIL en_freeze bit%0d xv got=%b exp=%b", 7 - i, {xout, valid}, {exp_bits[i], 1'b1});
            end
            if (i == 6) begin
                en = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    step();
                    checks++;
                    if ({xout, valid, busy} !== 3'b011) begin
                        errors++;
                        $display("FAIL en_freeze_hold%0d xvb got=%b exp=011", k, {xout, valid, busy});
                    end
                end
                en = 1'b1;
            end
        end
        step();
        checks++;
        if ({valid, done} !== 2'b01) begin
            errors++;
            $display("FAIL en_freeze_done vd got=%b exp=01", {valid, done});
        end
        checks++;
        if (vcount !== 8) begin
            errors++;
            $display("FAIL en_freeze_valid_count got=%0d exp=8", vcount);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp_bits;
        int seen = 0;
        exp_bits = 3'b101;
        pattern = 16'h00B5; nbits = 5'd8; repeats = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        checks++;
        if ({xout, valid} !== 2'b11) begin
            errors++;
            $display("FAIL reset_mid_bit4 xv got=%b exp=11", {xout, valid});
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({xout, valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_async xvbd got=%b exp=0000", {xout, valid, busy, done});
        end
        step();
        #2 reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (done || busy || valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done active_cycles got=%0d exp=0", seen);
        end
        pattern = 16'h0005; nbits = 5'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            if (i < 2) step();
            checks++;
            if ({xout, valid} !== {exp_bits[i], 1'b1}) begin
                errors++;
                $display("FAIL reset_mid_restart bit%0d xv got=%b exp=%b", 2 - i, {xout, valid}, {exp_bits[i], 1'b1});
            end
        end
        step();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_restart_done got=%b exp=1", done);
        end
        wait_idle();
    endtask

    task automatic test_nbits_zero();
        pattern = 16'hFFFF; nbits = 5'd0; repeats = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({xout, valid, busy, done} !== 4'b0001) begin
            errors++;
            $display("FAIL nbits_zero xvbd got=%b exp=0001", {xout, valid, busy, done});
        end
        en = 1'b0;
        step();
        checks++;
        if ({valid, done} !== 2'b01) begin
            errors++;
            $display("FAIL nbits_zero_stretch vd got=%b exp=01", {valid, done});
        end
        en = 1'b1;
        step();
        checks++;
        if ({xout, valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL nbits_zero_end xvbd got=%b exp=0000", {xout, valid, busy, done});
        end
    endtask

    task automatic test_saturate();
        logic [15:0] exp_bits;
        int vcount = 0;
        exp_bits = 16'b1100_0000_0000_0001;
        pattern = 16'hC001; nbits = 5'd20; repeats = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (i < 15) step();
            if (valid) vcount++;
            if (i >= 13 || i == 0) begin
                checks++;
                if ({xout, valid} !== {exp_bits[i], 1'b1}) begin
                    errors++;
                    $display("FAIL saturate bit%0d xv got=%b exp=%b", 15 - i, {xout, valid}, {exp_bits[i], 1'b1});
                end
            end
        end
        step();
        checks++;
        if ({done, vcount == 16} !== 2'b11) begin
            errors++;
            $display("FAIL saturate_len done=%b valid_count=%0d exp done=1 count=16", done, vcount);
        end
        wait_idle();
    endtask

    task automatic test_start_busy();
        logic [3:0] exp_bits;
        exp_bits = 4'b1101;
        pattern = 16'h000D; nbits = 5'd4; repeats = 4'd0; start = 1'b1;
        step();
        // Intruding request held high for the whole transmission.
        pattern = 16'h0000; nbits = 5'd1;
        for (int i = 3; i >= 0; i--) begin
            if (i < 3) step();
            checks++;
            if ({xout, valid, busy} !== {exp_bits[i], 2'b11}) begin
                errors++;
                $display("FAIL start_busy bit%0d xvb got=%b exp=%b", 3 - i, {xout, valid, busy}, {exp_bits[i], 2'b11});
            end
        end
        step();
        checks++;
        if ({xout, valid, busy, done} !== 4'b0001) begin
            errors++;
            $display("FAIL start_busy_done xvbd got=%b exp=0001", {xout, valid, busy, done});
        end
        step();
        checks++;
        if ({xout, valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL start_in_done_ignored xvbd got=%b exp=0000", {xout, valid, busy, done});
        end
        step();
        start = 1'b0;
        checks++;
        if ({xout, valid, busy, done} !== 4'b0110) begin
            errors++;
            $display("FAIL start_idle_accept xvbd got=%b exp=0110", {xout, valid, busy, done});
        end
        step();
        checks++;
        if ({xout, valid, busy, done} !== 4'b0001) begin
            errors++;
            $display("FAIL start_idle_done xvbd got=%b exp=0001", {xout, valid, busy, done});
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_detector();
        test_repeat_gap();
        test_back_to_back();
        test_en_freeze();
        test_reset_mid();
        test_nbits_zero();
        test_saturate();
        test_start_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
